// File: rtl/nes_palette_ctrl_if.sv
// Bus bundle for nes_palette_ctrl: pixel lookup channel, loader byte-write
// channel and status flags. The master drives lookups and loader writes;
// the slave (the palette controller) returns pixel data and status.
interface nes_palette_ctrl_if;
    logic        pix_ce;
    logic [5:0]  color;
    logic [14:0] pixel;
    logic        ld_wr;
    logic [6:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        ld_wait;
    logic        busy;

    modport master (
        output pix_ce, color, ld_wr, ld_addr, ld_data,
        input  pixel, ld_wait, busy
    );

    modport slave (
        input  pix_ce, color, ld_wr, ld_addr, ld_data,
        output pixel, ld_wait, busy
    );
endinterface

// File: rtl/nes_palette_ctrl.sv
// nes_palette_ctrl: single-port 64 x 15-bit palette RAM shared between video
// lookups (strict priority) and byte-wide loader uploads. After reset the RAM
// is filled with a default palette, one entry per cycle.
// Optional feature macro: PAL_DEFAULT_INIT_EN -- when defined the fill writes
// the built-in FCEUX palette; when undefined the fill writes zeros and no ROM
// is built.
module nes_palette_ctrl #(
    parameter int ENTRIES = 64
) (
    input  logic               clk,
    input  logic               reset,
    nes_palette_ctrl_if.slave  bus
);

    localparam int AW = 6;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [AW-1:0]   r_fill_idx, w_fill_idx_next;
    logic [7:0]      r_lat, w_lat_next;
    logic [14:0]     r_pend_data, w_pend_data_next;
    logic [AW-1:0]   r_pend_addr, w_pend_addr_next;

    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [14:0]     w_wdata;
    logic            w_rd;
    logic [14:0]     w_init_word;
    logic [14:0]     w_hi_word;
    logic            w_unused_bit;

    logic [14:0]     r_mem [0:ENTRIES-1];
    logic [14:0]     r_pixel;

    // High byte bit 7 carries no colour information.
    assign w_unused_bit = bus.ld_data[7];

`ifdef PAL_DEFAULT_INIT_EN
    // Pack 8-bit-per-channel 0xRRGGBB into {B[4:0], G[4:0], R[4:0]}.
    function automatic logic [14:0] rgb15(input logic [23:0] rgb);
        return {rgb[7:3], rgb[15:11], rgb[23:19]};
    endfunction

    // FCEUX default palette in 24-bit RGB.
    function automatic logic [23:0] fceux_rgb(input logic [AW-1:0] idx);
        logic [23:0] v;
        case (idx)
            6'h00: v = 24'h747474;  6'h01: v = 24'h24188C;  6'h02: v = 24'h0000A8;  6'h03: v = 24'h44009C;
            6'h04: v = 24'h8C0074;  6'h05: v = 24'hA80010;  6'h06: v = 24'hA40000;  6'h07: v = 24'h7C0800;
            6'h08: v = 24'h402C00;  6'h09: v = 24'h004400;  6'h0A: v = 24'h005000;  6'h0B: v = 24'h003C14;
            6'h0C: v = 24'h183C5C;  6'h10: v = 24'hBCBCBC;  6'h11: v = 24'h0070EC;  6'h12: v = 24'h2038EC;
            6'h13: v = 24'h8000F0;  6'h14: v = 24'hBC00BC;  6'h15: v = 24'hE40058;  6'h16: v = 24'hD82800;
            6'h17: v = 24'hC84C0C;  6'h18: v = 24'h887000;  6'h19: v = 24'h009400;  6'h1A: v = 24'h00A800;
            6'h1B: v = 24'h009038;  6'h1C: v = 24'h008088;  6'h20: v = 24'hFCFCFC;  6'h21: v = 24'h3CBCFC;
            6'h22: v = 24'h5C94FC;  6'h23: v = 24'hCC88FC;  6'h24: v = 24'hF478FC;  6'h25: v = 24'hFC74B4;
            6'h26: v = 24'hFC7460;  6'h27: v = 24'hFC9838;  6'h28: v = 24'hF0BC3C;  6'h29: v = 24'h80D010;
            6'h2A: v = 24'h4CDC48;  6'h2B: v = 24'h58F898;  6'h2C: v = 24'h00E8D8;  6'h2D: v = 24'h787878;
            6'h30: v = 24'hFCFCFC;  6'h31: v = 24'hA8E4FC;  6'h32: v = 24'hC4D4FC;  6'h33: v = 24'hD4C8FC;
            6'h34: v = 24'hFCC4FC;  6'h35: v = 24'hFCC4D8;  6'h36: v = 24'hFCBCB0;  6'h37: v = 24'hFCD8A8;
            6'h38: v = 24'hFCE4A0;  6'h39: v = 24'hE0FCA0;  6'h3A: v = 24'hA8F0BC;  6'h3B: v = 24'hB0FCCC;
            6'h3C: v = 24'h9CFCF0;  6'h3D: v = 24'hC4C4C4;
            default: v = 24'h000000;
        endcase
        return v;
    endfunction

    logic [14:0] w_rom [0:ENTRIES-1];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_rom
            assign w_rom[gi] = rgb15(fceux_rgb(AW'(gi)));
        end
    endgenerate

    assign w_init_word = w_rom[r_fill_idx];
`else
    assign w_init_word = 15'h0000;
`endif

    assign w_hi_word = {bus.ld_data[6:0], r_lat};

    // Next-state logic and RAM write/read arbitration; lookups always win the port.
    always_comb begin
        w_state_next     = r_state;
        w_fill_idx_next  = r_fill_idx;
        w_lat_next       = r_lat;
        w_pend_data_next = r_pend_data;
        w_pend_addr_next = r_pend_addr;
        w_we             = 1'b0;
        w_waddr          = r_pend_addr;
        w_wdata          = r_pend_data;
        w_rd             = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_we            = 1'b1;
                w_waddr         = r_fill_idx;
                w_wdata         = w_init_word;
                w_fill_idx_next = r_fill_idx + 1'b1;
                if (r_fill_idx == AW'(ENTRIES - 1))
                    w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                w_rd = bus.pix_ce;
                if (bus.ld_wr) begin
                    if (!bus.ld_addr[0]) begin
                        w_lat_next = bus.ld_data;
                    end else if (!bus.pix_ce) begin
                        w_we    = 1'b1;
                        w_waddr = bus.ld_addr[6:1];
                        w_wdata = w_hi_word;
                    end else begin
                        w_pend_data_next = w_hi_word;
                        w_pend_addr_next = bus.ld_addr[6:1];
                        w_state_next     = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                w_rd = bus.pix_ce;
                if (!bus.pix_ce) begin
                    w_we         = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // Controller state, fill pointer, byte latch and deferred-write holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_fill_idx  <= '0;
            r_lat       <= 8'h00;
            r_pend_data <= 15'h0000;
            r_pend_addr <= '0;
        end else begin
            r_state     <= w_state_next;
            r_fill_idx  <= w_fill_idx_next;
            r_lat       <= w_lat_next;
            r_pend_data <= w_pend_data_next;
            r_pend_addr <= w_pend_addr_next;
        end
    end

    // Palette RAM write port; contents are not reset, the fill sequence rewrites them.
    always_ff @(posedge clk) begin
        if (w_we && !reset)
            r_mem[w_waddr] <= w_wdata;
    end

    // Registered lookup; pixel holds between strobes.
    always_ff @(posedge clk) begin
        if (reset)
            r_pixel <= 15'h0000;
        else if (w_rd)
            r_pixel <= r_mem[bus.color];
    end

    assign bus.pixel   = r_pixel;
    assign bus.busy    = (r_state == ST_INIT);
    assign bus.ld_wait = (r_state != ST_IDLE);

endmodule
